// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto a single-ported memory.
// Data port wins ties; the fetch port is guaranteed a grant once it has lost
// STARVE_LIMIT consecutive cycles. Optional feature macro MEM_ARB_RMW_EN turns
// partial-byte stores into a two-cycle read-modify-write; without it every
// store is a single-cycle full-word write and d_be is ignored.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

`ifdef MEM_ARB_RMW_EN
  logic [29:0]   rmw_addr_q, rmw_addr_d;
  logic [31:0]   rmw_wdata_q, rmw_wdata_d;
  logic [31:0]   rmw_rdata_q, rmw_rdata_d;
  logic [3:0]    rmw_be_q, rmw_be_d;

  // Byte-lane merge: enabled lanes from the store data, others from the old word.
  function automatic logic [31:0] merge_word(input logic [31:0] wdata,
                                             input logic [31:0] rdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = rdata;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) begin
        res[8*n +: 8] = wdata[8*n +: 8];
      end else begin
        res[8*n +: 8] = rdata[8*n +: 8];
      end
    end
    return res;
  endfunction

  logic unused_bits_s;
  assign unused_bits_s = ^{if_addr[1:0], d_addr[1:0]};
`else
  logic unused_bits_s;
  assign unused_bits_s = ^{if_addr[1:0], d_addr[1:0], d_be};
`endif

  // Arbitration, memory-side drive, next-state and read-data capture.
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    mem_address    = 32'd0;
    mem_write_en   = 1'b0;
    mem_write_data = 32'd0;
`ifdef MEM_ARB_RMW_EN
    rmw_addr_d     = rmw_addr_q;
    rmw_wdata_d    = rmw_wdata_q;
    rmw_rdata_d    = rmw_rdata_q;
    rmw_be_d       = rmw_be_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req && (!if_req || (starve_q != LIMIT_C))) begin
          d_gnt       = 1'b1;
          mem_address = {d_addr[31:2], 2'b00};
          if (d_we) begin
`ifdef MEM_ARB_RMW_EN
            if (d_be == 4'b1111) begin
              mem_write_en   = 1'b1;
              mem_write_data = d_wdata;
            end else if (d_be == 4'b0000) begin
              mem_write_en   = 1'b0;
            end else begin
              // Read phase of a partial store: capture everything needed for the write.
              rmw_addr_d  = d_addr[31:2];
              rmw_wdata_d = d_wdata;
              rmw_rdata_d = mem_read_data;
              rmw_be_d    = d_be;
              state_d     = RMW_WR;
            end
`else
            mem_write_en   = 1'b1;
            mem_write_data = d_wdata;
`endif
          end else begin
            mem_write_en = 1'b0;
          end
        end else if (if_req) begin
          if_gnt      = 1'b1;
          mem_address = {if_addr[31:2], 2'b00};
        end else begin
          state_d = IDLE;
        end
      end
      RMW_WR: begin
`ifdef MEM_ARB_RMW_EN
        mem_address    = {rmw_addr_q, 2'b00};
        mem_write_en   = 1'b1;
        mem_write_data = merge_word(rmw_wdata_q, rmw_rdata_q, rmw_be_q);
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset must suppress grants and any memory write immediately.
    if (reset) begin
      if_gnt       = 1'b0;
      d_gnt        = 1'b0;
      mem_write_en = 1'b0;
    end else begin
      mem_write_en = mem_write_en;
    end

    if (if_gnt) begin
      starve_d = '0;
    end else if (if_req && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end

    if_rvalid_d = if_gnt;
    d_rvalid_d  = d_gnt && !d_we;
    if (if_gnt) begin
      if_rdata_d = mem_read_data;
    end else begin
      if_rdata_d = if_rdata_q;
    end
    if (d_gnt && !d_we) begin
      d_rdata_d = mem_read_data;
    end else begin
      d_rdata_d = d_rdata_q;
    end
  end

  // State, starvation counter and read-return registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_RMW_EN
  // Latched partial-store context carried into the write phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rmw_addr_q  <= 30'd0;
      rmw_wdata_q <= 32'd0;
      rmw_rdata_q <= 32'd0;
      rmw_be_q    <= 4'd0;
    end else begin
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_rdata_q <= rmw_rdata_d;
      rmw_be_q    <= rmw_be_d;
    end
  end
`endif

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write_en;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [0:15];
  logic [31:0] model_mem [0:15];
  int          starve;
  bit          busy;
  logic [31:0] busy_addr, busy_data;
  logic [31:0] m_if_rdata, m_d_rdata;
  int          checks = 0;
  int          failures = 0;

  assign mem_read_data = mem[mem_address[5:2]];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx]       = val;
    model_mem[idx] = val;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_be = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
  endtask

  task automatic model_reset();
    starve = 0; busy = 1'b0; busy_addr = 32'd0; busy_data = 32'd0;
    m_if_rdata = 32'd0; m_d_rdata = 32'd0;
  endtask

  // Pulse reset for one cycle; returns at a falling edge with reset low.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One arbitration cycle: inputs are already driven just after a falling edge.
  task automatic step();
    bit          e_ig, e_dg, e_we, rd_if, rd_d, nxt_busy;
    logic [31:0] e_addr, e_wd, n_addr, n_data, old_w;
    logic        w_en;
    logic [31:0] w_addr, w_data;
    #1;
    e_ig = 0; e_dg = 0; e_we = 0; rd_if = 0; rd_d = 0; nxt_busy = 0;
    e_addr = 32'd0; e_wd = 32'd0; n_addr = 32'd0; n_data = 32'd0;
    if (busy) begin
      e_we = 1; e_addr = busy_addr; e_wd = busy_data;
    end else if (d_req && !(if_req && starve == LIMIT)) begin
      e_dg = 1;
      e_addr = d_addr & 32'hFFFF_FFFC;
      if (!d_we) begin
        rd_d = 1;
      end else begin
`ifdef MEM_ARB_RMW_EN
        if (d_be == 4'hF) begin
          e_we = 1; e_wd = d_wdata;
        end else if (d_be != 4'h0) begin
          old_w = model_mem[e_addr[5:2]];
          n_data = 32'd0;
          for (int n = 0; n < 4; n++)
            n_data[8*n +: 8] = d_be[n] ? d_wdata[8*n +: 8] : old_w[8*n +: 8];
          nxt_busy = 1; n_addr = e_addr;
        end
`else
        e_we = 1; e_wd = d_wdata;
`endif
      end
    end else if (if_req) begin
      e_ig = 1; e_addr = if_addr & 32'hFFFF_FFFC; rd_if = 1;
    end
    check_eq("if_gnt", if_gnt, e_ig);
    check_eq("d_gnt", d_gnt, e_dg);
    check_eq("mem_we", mem_write_en, e_we);
    check_eq("mem_addr", mem_address, e_addr);
    if (e_we) check_eq("mem_wdata", mem_write_data, e_wd);
    if (rd_if) m_if_rdata = model_mem[e_addr[5:2]];
    if (rd_d)  m_d_rdata  = model_mem[e_addr[5:2]];
    w_en = mem_write_en; w_addr = mem_address; w_data = mem_write_data;
    if (e_ig) starve = 0;
    else if (if_req && starve < LIMIT) starve++;
    if (e_we) model_mem[e_addr[5:2]] = e_wd;
    busy = nxt_busy; busy_addr = n_addr; busy_data = n_data;
    @(posedge clk);
    #1;
    if (w_en) mem[w_addr[5:2]] = w_data;
    check_eq("if_rvalid", if_rvalid, rd_if);
    check_eq("d_rvalid", d_rvalid, rd_d);
    check_eq("if_rdata", if_rdata, m_if_rdata);
    check_eq("d_rdata", d_rdata, m_d_rdata);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    for (int i = 0; i < 16; i++) preload(i, 32'h1000_0000 + i);
    @(negedge clk);
    #1;
    check_eq("rst_if_gnt", if_gnt, 32'd0);
    check_eq("rst_d_rvalid", d_rvalid, 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_mem_we", mem_write_en, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fetch of an unaligned address returns the containing word.
    preload(3, 32'hE1A0_0000);
    if_req = 1'b1; if_addr = 32'h0000_000E;
    step();
    if_req = 1'b0;
    check_eq("fetch_word", if_rdata, 32'hE1A0_0000);

    // Continuous contention: fetch wins every fifth cycle.
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008;
    for (int k = 0; k < 12; k++) begin
      #1;
      check_eq("starve_pat", if_gnt, ((k % 5) == 4) ? 32'd1 : 32'd0);
      step();
    end

    // Partial store.
    do_reset();
    preload(4, 32'h1122_3344);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0101; d_addr = 32'h0000_0010; d_wdata = 32'hAABB_CCDD;
    step();
    idle_inputs();
    step();
`ifdef MEM_ARB_RMW_EN
    check_eq("rmw_merge", mem[4], 32'h11BB_33DD);
`else
    check_eq("full_store", mem[4], 32'hAABB_CCDD);
`endif

`ifdef MEM_ARB_RMW_EN
    // Reset in the write phase of a partial store: the write must be dropped.
    do_reset();
    preload(4, 32'h1122_3344);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0101; d_addr = 32'h0000_0010; d_wdata = 32'hAABB_CCDD;
    step();
    d_req = 1'b1; d_we = 1'b0; if_req = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("rstrmw_we", mem_write_en, 32'd0);
    check_eq("rstrmw_if_gnt", if_gnt, 32'd0);
    check_eq("rstrmw_d_gnt", d_gnt, 32'd0);
    check_eq("rstrmw_d_rdata", d_rdata, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rstrmw_mem", mem[4], 32'h1122_3344);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    model_reset();
    step();
`endif

    // Full-word store followed by fetch of the same word.
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 32'h0000_0020; d_wdata = 32'hCAFE_F00D;
    step();
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h0000_0020;
    step();
    idle_inputs();
    check_eq("store_fetch", if_rdata, 32'hCAFE_F00D);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int sel;
      if_req  = ($urandom_range(0, 3) != 0);
      if_addr = $urandom();
      d_req   = ($urandom_range(0, 3) != 0);
      d_we    = $urandom_range(0, 1) == 1;
      d_addr  = $urandom();
      d_wdata = $urandom();
      sel = $urandom_range(0, 5);
      d_be = (sel == 0) ? 4'b0000 : (sel == 1) ? 4'b1111 : 4'($urandom_range(0, 15));
      step();
    end
    idle_inputs();
    step();
    step();
    for (int i = 0; i < 16; i++) check_eq("final_mem", mem[i], model_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
